// File: rtl/osnt_restore_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | osnt_restore_pkg : shared widths, FSM states and tkeep helper functions   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package osnt_restore_pkg;

   localparam int DATA_WIDTH     = 256;
   localparam int KEEP_WIDTH     = DATA_WIDTH / 8;
   localparam int TUSER_WIDTH    = 128;
   localparam int BYTES_PER_BEAT = 32;
   localparam int LEN_WIDTH      = 16;

   typedef enum logic [0:0] {
      PASS = 1'b0,
      PAD  = 1'b1
   } state_t;

   function automatic logic [5:0] keep_to_count(input logic [31:0] keep);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) begin
         n = n + {5'b0, keep[i]};
      end
      return n;
   endfunction

   // Counts of 32 or more give an all-ones mask.
   function automatic logic [31:0] count_to_keep(input logic [5:0] n);
      logic [31:0] k;
      for (int i = 0; i < 32; i++) begin
         k[i] = (6'(i) < n);
      end
      return k;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tkeep_fill_mask.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tkeep_fill_mask : fill-lane mask and output tkeep for a padded last beat |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tkeep_fill_mask
   import osnt_restore_pkg::*;
(
   input  logic [5:0]  i_n,
   input  logic [15:0] i_d,
   output logic [31:0] o_fill_mask,
   output logic [31:0] o_keep,
   output logic        o_fits
);

   logic [5:0] w_space;
   logic [5:0] w_fill;
   logic [5:0] w_total;

   always_comb begin
      w_space     = 6'd32 - i_n;
      o_fits      = (i_d <= {10'b0, w_space});
      w_fill      = o_fits ? i_d[5:0] : w_space;
      w_total     = i_n + w_fill;
      o_keep      = count_to_keep(w_total);
      o_fill_mask = o_keep & ~count_to_keep(i_n);
   end

endmodule
`default_nettype wire

// File: rtl/osnt_sume_length_restorer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | osnt_sume_length_restorer : pads snapped packets back to tuser length.   |
// | Optional LENGTH_RESTORE_STATS_EN adds the padded_pkts counter. Rev 1.0   |
// +--------------------------------------------------------------------------+
module osnt_sume_length_restorer
   import osnt_restore_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXI_DATA_WIDTH   = 32
) (
   input  logic                              axi_aclk,
   input  logic                              axi_reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   input  logic                              pad_en,
   input  logic [7:0]                        pad_byte
`ifdef LENGTH_RESTORE_STATS_EN
   ,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     padded_pkts
`endif
);

   if ((C_M_AXIS_DATA_WIDTH != DATA_WIDTH) || (C_S_AXIS_DATA_WIDTH != DATA_WIDTH) ||
       (C_M_AXIS_TUSER_WIDTH != TUSER_WIDTH) || (C_S_AXIS_TUSER_WIDTH != TUSER_WIDTH) ||
       (C_S_AXI_DATA_WIDTH < 1)) begin : g_cfg_check
      $error("osnt_sume_length_restorer: unsupported width configuration");
   end

   state_t                  r_state, w_state_nxt;
   logic                    r_first, w_first_nxt;
   logic [LEN_WIDTH-1:0]    r_cnt, w_cnt_nxt;
   logic [LEN_WIDTH-1:0]    r_rem, w_rem_nxt;
   logic [LEN_WIDTH-1:0]    r_target, w_target;
   logic                    r_pad_en, w_pad_en;
   logic [7:0]              r_pad_byte, w_pad_byte;
   logic [TUSER_WIDTH-1:0]  r_tuser, w_tuser;

   logic [DATA_WIDTH-1:0]   r_m_tdata, w_m_tdata_nxt;
   logic [KEEP_WIDTH-1:0]   r_m_tkeep, w_m_tkeep_nxt;
   logic [TUSER_WIDTH-1:0]  r_m_tuser, w_m_tuser_nxt;
   logic                    r_m_tvalid, w_m_tvalid_nxt;
   logic                    r_m_tlast, w_m_tlast_nxt;

   logic                    w_load, w_accept, w_need_pad, w_pad_inc;
   logic [5:0]              w_n;
   logic [LEN_WIDTH:0]      w_sum;
   logic [LEN_WIDTH-1:0]    w_r, w_d;
   logic [31:0]             w_fill_mask, w_fill_keep;
   logic                    w_fits;
   logic [DATA_WIDTH-1:0]   w_fill_data;

   // Config and tuser come straight from the bus on the first beat, else from the latch.
   assign w_target   = r_first ? s_axis_tuser[LEN_WIDTH-1:0] : r_target;
   assign w_pad_en   = r_first ? pad_en   : r_pad_en;
   assign w_pad_byte = r_first ? pad_byte : r_pad_byte;
   assign w_tuser    = r_first ? s_axis_tuser : r_tuser;

   assign w_n        = keep_to_count(s_axis_tkeep);
   assign w_sum      = {1'b0, (r_first ? {LEN_WIDTH{1'b0}} : r_cnt)} + {11'b0, w_n};
   assign w_r        = w_sum[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : w_sum[LEN_WIDTH-1:0];
   assign w_d        = w_target - w_r;
   assign w_need_pad = w_pad_en && (w_r < w_target);

   assign w_load        = !r_m_tvalid || m_axis_tready;
   assign s_axis_tready = !axi_reset && (r_state == PASS) && w_load;
   assign w_accept      = s_axis_tvalid && s_axis_tready;

   tkeep_fill_mask u_fill (
      .i_n         (w_n),
      .i_d         (w_d),
      .o_fill_mask (w_fill_mask),
      .o_keep      (w_fill_keep),
      .o_fits      (w_fits)
   );

   for (genvar gi = 0; gi < BYTES_PER_BEAT; gi++) begin : g_lane
      assign w_fill_data[8*gi +: 8] = w_fill_mask[gi] ? w_pad_byte : s_axis_tdata[8*gi +: 8];
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_first_nxt    = r_first;
      w_cnt_nxt      = r_cnt;
      w_rem_nxt      = r_rem;
      w_m_tdata_nxt  = r_m_tdata;
      w_m_tkeep_nxt  = r_m_tkeep;
      w_m_tuser_nxt  = r_m_tuser;
      w_m_tvalid_nxt = r_m_tvalid;
      w_m_tlast_nxt  = r_m_tlast;
      w_pad_inc      = 1'b0;
      case (r_state)
         PASS: begin
            if (w_accept) begin
               w_first_nxt    = s_axis_tlast;
               w_cnt_nxt      = w_r;
               w_m_tdata_nxt  = s_axis_tdata;
               w_m_tkeep_nxt  = s_axis_tkeep;
               w_m_tuser_nxt  = w_tuser;
               w_m_tvalid_nxt = 1'b1;
               w_m_tlast_nxt  = s_axis_tlast;
               if (s_axis_tlast && w_need_pad) begin
                  w_pad_inc     = 1'b1;
                  w_m_tdata_nxt = w_fill_data;
                  w_m_tkeep_nxt = w_fits ? w_fill_keep : {KEEP_WIDTH{1'b1}};
                  w_m_tlast_nxt = w_fits;
                  if (!w_fits) begin
                     w_state_nxt = PAD;
                     w_rem_nxt   = w_d - {10'b0, (6'd32 - w_n)};
                  end
               end
            end else if (w_load) begin
               w_m_tvalid_nxt = 1'b0;
            end
         end
         PAD: begin
            if (w_load) begin
               w_m_tdata_nxt  = {BYTES_PER_BEAT{r_pad_byte}};
               w_m_tuser_nxt  = r_tuser;
               w_m_tvalid_nxt = 1'b1;
               if (r_rem <= 16'd32) begin
                  w_m_tkeep_nxt = count_to_keep(r_rem[5:0]);
                  w_m_tlast_nxt = 1'b1;
                  w_state_nxt   = PASS;
               end else begin
                  w_m_tkeep_nxt = {KEEP_WIDTH{1'b1}};
                  w_m_tlast_nxt = 1'b0;
                  w_rem_nxt     = r_rem - 16'd32;
               end
            end
         end
         default: w_state_nxt = PASS;
      endcase
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         r_state    <= PASS;
         r_first    <= 1'b1;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_target   <= '0;
         r_pad_en   <= 1'b0;
         r_pad_byte <= '0;
         r_tuser    <= '0;
         r_m_tdata  <= '0;
         r_m_tkeep  <= '0;
         r_m_tuser  <= '0;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_first    <= w_first_nxt;
         r_cnt      <= w_cnt_nxt;
         r_rem      <= w_rem_nxt;
         r_m_tdata  <= w_m_tdata_nxt;
         r_m_tkeep  <= w_m_tkeep_nxt;
         r_m_tuser  <= w_m_tuser_nxt;
         r_m_tvalid <= w_m_tvalid_nxt;
         r_m_tlast  <= w_m_tlast_nxt;
         if (w_accept && r_first) begin
            r_target   <= w_target;
            r_pad_en   <= w_pad_en;
            r_pad_byte <= w_pad_byte;
            r_tuser    <= w_tuser;
         end
      end
   end

   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tkeep  = r_m_tkeep;
   assign m_axis_tuser  = r_m_tuser;
   assign m_axis_tvalid = r_m_tvalid;
   assign m_axis_tlast  = r_m_tlast;

`ifdef LENGTH_RESTORE_STATS_EN
   logic [C_S_AXI_DATA_WIDTH-1:0] r_padded;

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         r_padded <= '0;
      end else if (w_pad_inc) begin
         r_padded <= r_padded + 1'b1;
      end
   end

   assign padded_pkts = r_padded;
`endif

endmodule
`default_nettype wire
